// File: rtl/trig_capture_buf.sv
// rtl/trig_capture_buf.sv - multi-channel triggered sample store with circular RAM and oldest-first readback
`timescale 1ns/1ps
module trig_capture_buf #(
  parameter int NUM_CH  = 2,
  parameter int CH_W    = 12,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int CHSEL_W = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [NUM_CH*CH_W-1:0]   in_data,
  input  logic                     arm,
  input  logic                     force_trig,
  input  logic [1:0]               cfg_mode,
  input  logic [CHSEL_W-1:0]       cfg_chan,
  input  logic [CH_W-1:0]          cfg_level,
  input  logic [ADDR_W-1:0]        cfg_pretrig,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [NUM_CH*CH_W-1:0]   rd_data,
  output logic                     complete,
  output logic                     busy,
  output logic [2:0]               state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRETRIG = 3'd1,
    S_WAIT    = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                  r_state;
  logic                    r_complete;
  logic                    r_busy;
  logic [ADDR_W-1:0]       r_wr_ptr;
  logic [ADDR_W-1:0]       r_cnt;
  logic [ADDR_W-1:0]       r_post_cnt;
  logic [ADDR_W-1:0]       r_start_ptr;
  logic                    r_prev_valid;
  logic                    r_prev_above;
  logic [1:0]              r_mode;
  logic [CHSEL_W-1:0]      r_chan;
  logic [CH_W-1:0]         r_level;
  logic [ADDR_W-1:0]       r_pretrig;
  logic [NUM_CH*CH_W-1:0]  r_rd_data;
  logic [NUM_CH*CH_W-1:0]  r_ram [DEPTH];

  int                      w_chan_idx;
  logic [CH_W-1:0]         w_sample;
  logic                    w_above;
  logic                    w_busy_st;
  logic                    w_we;
  logic                    w_edge;
  logic                    w_trig;
  logic [ADDR_W-1:0]       w_post_init;
  logic [ADDR_W-1:0]       w_rd_idx;

  // Pick the trigger channel; out-of-range selections fall back to channel 0
  always_comb begin
    w_chan_idx = (int'(r_chan) < NUM_CH) ? int'(r_chan) : 0;
    w_sample   = in_data[CH_W-1:0];
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_chan_idx == k) w_sample = in_data[k*CH_W +: CH_W];
    end
  end

  // Edge detection against the previous valid sample; the first sample after arm has no history
  always_comb begin
    w_edge = 1'b0;
    case (r_mode)
      2'd0:    w_edge = r_prev_valid & ~r_prev_above &  w_above;
      2'd1:    w_edge = r_prev_valid &  r_prev_above & ~w_above;
      2'd2:    w_edge = r_prev_valid & (r_prev_above != w_above);
      default: w_edge = 1'b1;
    endcase
  end

  assign w_above     = (w_sample >= r_level);
  assign w_busy_st   = (r_state == S_PRETRIG) || (r_state == S_WAIT) || (r_state == S_POST);
  assign w_we        = in_valid & ~arm & w_busy_st;
  assign w_trig      = w_edge | force_trig;
  // DEPTH - pretrig - 1 is the bitwise complement of pretrig for a power-of-two DEPTH
  assign w_post_init = ~r_pretrig;
  assign w_rd_idx    = r_start_ptr + rd_addr;

  // Capture FSM: arm restarts from any state, otherwise advance on each written sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_complete   <= 1'b0;
      r_busy       <= 1'b0;
      r_wr_ptr     <= '0;
      r_cnt        <= '0;
      r_post_cnt   <= '0;
      r_start_ptr  <= '0;
      r_prev_valid <= 1'b0;
      r_prev_above <= 1'b0;
      r_mode       <= '0;
      r_chan       <= '0;
      r_level      <= '0;
      r_pretrig    <= '0;
    end else if (arm) begin
      r_mode       <= cfg_mode;
      r_chan       <= cfg_chan;
      r_level      <= cfg_level;
      r_pretrig    <= cfg_pretrig;
      r_wr_ptr     <= '0;
      r_cnt        <= '0;
      r_prev_valid <= 1'b0;
      r_complete   <= 1'b0;
      r_busy       <= 1'b1;
      r_state      <= (cfg_pretrig == '0) ? S_WAIT : S_PRETRIG;
    end else if (w_we) begin
      r_wr_ptr     <= r_wr_ptr + ADDR_W'(1);
      r_prev_above <= w_above;
      r_prev_valid <= 1'b1;
      case (r_state)
        S_PRETRIG: begin
          r_cnt <= r_cnt + ADDR_W'(1);
          if (r_cnt == r_pretrig - ADDR_W'(1)) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_trig) begin
            r_start_ptr <= r_wr_ptr - r_pretrig;
            r_post_cnt  <= w_post_init;
            if (w_post_init == '0) begin
              r_state    <= S_DONE;
              r_complete <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_state <= S_POST;
            end
          end
        end
        S_POST: begin
          r_post_cnt <= r_post_cnt - ADDR_W'(1);
          if (r_post_cnt == ADDR_W'(1)) begin
            r_state    <= S_DONE;
            r_complete <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Sample RAM write port
  always_ff @(posedge clk) begin
    if (w_we) r_ram[r_wr_ptr] <= in_data;
  end

  // Registered read port, addressed relative to the oldest captured sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rd_data <= '0;
    else       r_rd_data <= r_ram[w_rd_idx];
  end

  assign rd_data  = r_rd_data;
  assign complete = r_complete;
  assign busy     = r_busy;
  assign state    = r_state;

endmodule

// File: tb/tb_trig_capture_buf.sv
// tb/tb_trig_capture_buf.sv - directed table-driven bench for trig_capture_buf
`timescale 1ns/1ps
module tb_trig_capture_buf;
  localparam int NUM_CH = 2, CH_W = 12, DEPTH = 16, ADDR_W = 4, CHSEL_W = 1;
  localparam int DW = NUM_CH * CH_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              arm = 1'b0;
  logic              force_trig = 1'b0;
  logic [1:0]        cfg_mode = '0;
  logic [CHSEL_W-1:0] cfg_chan = '0;
  logic [CH_W-1:0]   cfg_level = '0;
  logic [ADDR_W-1:0] cfg_pretrig = '0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DW-1:0]     rd_data;
  logic              complete;
  logic              busy;
  logic [2:0]        state;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     exp_data;
  } rd_vec_t;

  rd_vec_t ramp_tbl [8];

  trig_capture_buf #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CHSEL_W(CHSEL_W)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .arm(arm), .force_trig(force_trig), .cfg_mode(cfg_mode), .cfg_chan(cfg_chan),
    .cfg_level(cfg_level), .cfg_pretrig(cfg_pretrig), .rd_addr(rd_addr),
    .rd_data(rd_data), .complete(complete), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [11:0] c0, input logic [11:0] c1);
    @(negedge clk);
    in_valid = v;
    in_data  = {c1, c0};
  endtask

  // Drive one sample and wait until just after the edge that consumes it
  task automatic step(input logic v, input logic [11:0] c0, input logic [11:0] c1);
    drive(v, c0, c1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [11:0] lvl, input logic [3:0] pt);
    @(negedge clk);
    in_valid    = 1'b0;
    arm         = 1'b1;
    cfg_mode    = m;
    cfg_chan    = 1'b0;
    cfg_level   = lvl;
    cfg_pretrig = pt;
    @(negedge clk);
    arm         = 1'b0;
    cfg_mode    = 2'd3;
    cfg_level   = 12'd0;
    cfg_pretrig = 4'd0;
  endtask

  task automatic rd_check(input string name, input logic [3:0] a, input logic [DW-1:0] exp);
    @(negedge clk);
    in_valid = 1'b0;
    rd_addr  = a;
    @(negedge clk);
    check(name, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    ramp_tbl[0] = '{4'd0,  {12'd256, 12'd16}};
    ramp_tbl[1] = '{4'd1,  {12'd272, 12'd17}};
    ramp_tbl[2] = '{4'd3,  {12'd304, 12'd19}};
    ramp_tbl[3] = '{4'd4,  {12'd320, 12'd20}};
    ramp_tbl[4] = '{4'd5,  {12'd336, 12'd21}};
    ramp_tbl[5] = '{4'd10, {12'd416, 12'd26}};
    ramp_tbl[6] = '{4'd14, {12'd480, 12'd30}};
    ramp_tbl[7] = '{4'd15, {12'd496, 12'd31}};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'(state), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_complete", 32'(complete), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    reset = 1'b0;

    // Rising-edge ramp capture; config inputs scrambled after arm must not matter
    do_arm(2'd0, 12'd20, 4'd4);
    check("t1_arm_state", 32'(state), 32'd1);
    for (int n = 0; n < 32; n++) begin
      step(1'b1, 12'(n), 12'(n * 16));
      if (n == 10) check("t1_busy", 32'(busy), 32'd1);
      if (n == 19) check("t1_wait_before_trig", 32'(state), 32'd2);
      if (n == 20) check("t1_post_after_trig", 32'(state), 32'd3);
      if (n == 30) check("t1_not_complete_30", 32'(complete), 32'd0);
      if (n == 31) begin
        check("t1_complete_31", 32'(complete), 32'd1);
        check("t1_done_state", 32'(state), 32'd4);
        check("t1_done_busy", 32'(busy), 32'd0);
      end
    end
    for (int i = 0; i < 8; i++)
      rd_check($sformatf("t1_rd_addr%0d", ramp_tbl[i].addr), ramp_tbl[i].addr, ramp_tbl[i].exp_data);

    // Same capture with gaps between valid samples
    do_arm(2'd0, 12'd20, 4'd4);
    for (int n = 0; n < 32; n++) begin
      step(1'b1, 12'(n), 12'(n * 16));
      if (n == 30) check("t2_not_complete_30", 32'(complete), 32'd0);
      if (n == 31) check("t2_complete_31", 32'(complete), 32'd1);
      step(1'b0, 12'hABC, 12'hDEF);
      if (n == 20) check("t2_post_hold", 32'(state), 32'd3);
    end
    for (int i = 0; i < 8; i++)
      rd_check($sformatf("t2_rd_addr%0d", ramp_tbl[i].addr), ramp_tbl[i].addr, ramp_tbl[i].exp_data);

    // Forced immediate trigger with no pre-trigger history
    do_arm(2'd3, 12'd0, 4'd0);
    check("t3_arm_wait", 32'(state), 32'd2);
    for (int n = 0; n < 16; n++) begin
      step(1'b1, 12'(100 + n), 12'(n));
      if (n == 0) check("t3_post_first", 32'(state), 32'd3);
      if (n == 14) check("t3_not_complete", 32'(complete), 32'd0);
      if (n == 15) check("t3_complete", 32'(complete), 32'd1);
    end
    rd_check("t3_rd0", 4'd0, {12'd0, 12'd100});
    rd_check("t3_rd7", 4'd7, {12'd7, 12'd107});
    rd_check("t3_rd15", 4'd15, {12'd15, 12'd115});

    // Falling edge on a square wave, pretrig fills the window so trigger ends capture
    do_arm(2'd1, 12'd100, 4'd15);
    check("t4_arm_state", 32'(state), 32'd1);
    for (int i = 0; i < 21; i++) begin
      step(1'b1, ((i % 8) < 4) ? 12'd200 : 12'd50, 12'(i));
      if (i == 14) check("t4_wait_entry", 32'(state), 32'd2);
      if (i == 19) check("t4_wait_19", 32'(state), 32'd2);
      if (i == 20) begin
        check("t4_done_state", 32'(state), 32'd4);
        check("t4_complete", 32'(complete), 32'd1);
      end
    end
    rd_check("t4_rd15", 4'd15, {12'd20, 12'd50});
    rd_check("t4_rd14", 4'd14, {12'd19, 12'd200});
    rd_check("t4_rd0", 4'd0, {12'd5, 12'd50});

    // Either-edge on a constant input never fires until force_trig
    do_arm(2'd2, 12'd20, 4'd2);
    for (int i = 0; i < 10; i++) step(1'b1, 12'd500, 12'(i));
    check("t5_stuck_wait", 32'(state), 32'd2);
    check("t5_stuck_busy", 32'(busy), 32'd1);
    check("t5_stuck_complete", 32'(complete), 32'd0);
    force_trig = 1'b1;
    step(1'b1, 12'd500, 12'd10);
    force_trig = 1'b0;
    check("t5_forced_post", 32'(state), 32'd3);
    for (int i = 11; i < 24; i++) begin
      step(1'b1, 12'd500, 12'(i));
      if (i == 22) check("t5_not_complete", 32'(complete), 32'd0);
      if (i == 23) check("t5_complete", 32'(complete), 32'd1);
    end
    rd_check("t5_rd2_trig", 4'd2, {12'd10, 12'd500});
    rd_check("t5_rd0", 4'd0, {12'd8, 12'd500});

    // Re-arm from DONE, re-arm mid-POSTTRIG, then asynchronous reset mid-WAIT_TRIG
    do_arm(2'd0, 12'd20, 4'd4);
    check("t6_rearm_done_state", 32'(state), 32'd1);
    check("t6_rearm_done_complete", 32'(complete), 32'd0);
    for (int n = 0; n < 25; n++) step(1'b1, 12'(n), 12'(n * 16));
    check("t6_mid_post", 32'(state), 32'd3);
    do_arm(2'd0, 12'd20, 4'd4);
    check("t6_rearm_post_state", 32'(state), 32'd1);
    check("t6_rearm_post_busy", 32'(busy), 32'd1);
    check("t6_rearm_post_complete", 32'(complete), 32'd0);
    for (int n = 0; n < 10; n++) step(1'b1, 12'(n), 12'(n * 16));
    check("t6_mid_wait", 32'(state), 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    rd_addr  = 4'd5;
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_state", 32'(state), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_complete", 32'(complete), 32'd0);
    check("t6_async_rd_data", 32'(rd_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 12'd7, 12'd7);
    check("t6_idle_after_reset", 32'(state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
